// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage buffer.
// Payload widths default to 32/4/6 when the enclosing build does not define
// WORD_SIZE, INSTR_TYPE_SZ and ROB_ENTRY_WIDTH.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

package pipe_pkg;

  localparam int unsigned DEFAULT_DEPTH = 2;
  localparam int unsigned PTR_W         = $clog2(DEFAULT_DEPTH);
  localparam int unsigned CNT_W         = $clog2(DEFAULT_DEPTH + 1);

  typedef struct packed {
    logic [`INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [`WORD_SIZE-1:0]       pc;
    logic [`WORD_SIZE-1:0]       aluResult;
    logic [`ROB_ENTRY_WIDTH-1:0] rob_id;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline stage: circular buffer of DEPTH in-flight instructions.
// stall_out depends only on registered occupancy, so there is no combinational
// path from the downstream stall to the upstream stage.
// Optional feature macro: PIPE_STAGE_KILL_EN (adds kill_valid / kill_rob_id
// to squash stored entries by rob_id, leaving them as bubbles).
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned WORD_SIZE       = `WORD_SIZE,
  parameter int unsigned INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
  parameter int unsigned ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
  parameter int unsigned DEPTH           = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         valid,
  input  logic [INSTR_TYPE_SZ-1:0]     instruction_type,
  input  logic [WORD_SIZE-1:0]         pc,
  input  logic [WORD_SIZE-1:0]         aluResult,
  input  logic [ROB_ENTRY_WIDTH-1:0]   rob_id,
  output logic                         stall_out,
  input  logic                         stall,
  output logic                         valid_out,
  output logic [INSTR_TYPE_SZ-1:0]     instruction_type_out,
  output logic [WORD_SIZE-1:0]         pc_out,
  output logic [WORD_SIZE-1:0]         aluResult_out,
  output logic [ROB_ENTRY_WIDTH-1:0]   rob_id_out,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STAGE_KILL_EN
  ,
  input  logic                         kill_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0]   kill_rob_id
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  pipe_entry_t          mem_q [DEPTH];
  pipe_entry_t          mem_d [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  pipe_entry_t          out_q, out_d;

  pipe_entry_t          in_entry;
  logic                 full;
  logic                 head_valid;
  logic                 push;
  logic                 pop;
  logic                 push_killed;

  // Handshake decode from registered state only.
  always_comb begin
    in_entry.instruction_type = instruction_type;
    in_entry.pc               = pc;
    in_entry.aluResult        = aluResult;
    in_entry.rob_id           = rob_id;
    full       = (cnt_q == CW'(DEPTH));
    head_valid = vld_q[rd_ptr_q];
    push       = valid & ~full;
    // A killed head is a bubble and leaves without waiting for downstream.
    pop        = (cnt_q != '0) & (~stall | ~head_valid);
  end

  // Next-state for storage, valid bits, pointers and count.
  always_comb begin
    mem_d       = mem_q;
    vld_d       = vld_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    push_killed = 1'b0;

`ifdef PIPE_STAGE_KILL_EN
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill_valid && (mem_q[i].rob_id == kill_rob_id)) begin
        vld_d[i] = 1'b0;
      end
    end
    push_killed = kill_valid && (rob_id == kill_rob_id);
`endif

    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end

    // push and pop never share a slot: that needs count 0 (no pop) or full (no push).
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      vld_d[wr_ptr_q] = ~push_killed;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // flush drops occupancy and any same-cycle push; payload storage is kept.
    if (flush) begin
      mem_d    = mem_q;
      vld_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Output payload register: tracks the next head, holds the last value when empty.
  always_comb begin
    out_d = out_q;
    if (cnt_d != '0) begin
      out_d = mem_d[rd_ptr_d];
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  // Output drive.
  always_comb begin
    stall_out            = full;
    valid_out            = (cnt_q != '0) & head_valid;
    occupancy            = cnt_q;
    instruction_type_out = out_q.instruction_type;
    pc_out               = out_q.pc;
    aluResult_out        = out_q.aluResult;
    rob_id_out           = out_q.rob_id;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed self-checking bench for pipe_stage_buffer (DEPTH=2 and DEPTH=4
// instances sharing the same stimulus; each scenario checks one instance).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

module tb_pipe_stage_buffer;

  logic clk = 1'b0;
  logic reset, flush, valid, stall;
  logic [`INSTR_TYPE_SZ-1:0]   itype;
  logic [`WORD_SIZE-1:0]       pc, alu;
  logic [`ROB_ENTRY_WIDTH-1:0] rob;
  logic                        kill_valid;
  logic [`ROB_ENTRY_WIDTH-1:0] kill_rob;

  logic                        s2, v2, s4, v4;
  logic [`INSTR_TYPE_SZ-1:0]   t2, t4;
  logic [`WORD_SIZE-1:0]       p2, a2, p4, a4;
  logic [`ROB_ENTRY_WIDTH-1:0] r2, r4;
  logic [1:0]                  o2;
  logic [2:0]                  o4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .valid(valid),
    .instruction_type(itype), .pc(pc), .aluResult(alu), .rob_id(rob),
    .stall_out(s2), .stall(stall), .valid_out(v2),
    .instruction_type_out(t2), .pc_out(p2), .aluResult_out(a2), .rob_id_out(r2),
    .occupancy(o2)
`ifdef PIPE_STAGE_KILL_EN
    , .kill_valid(kill_valid), .kill_rob_id(kill_rob)
`endif
  );

  pipe_stage_buffer #(.DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .flush(flush), .valid(valid),
    .instruction_type(itype), .pc(pc), .aluResult(alu), .rob_id(rob),
    .stall_out(s4), .stall(stall), .valid_out(v4),
    .instruction_type_out(t4), .pc_out(p4), .aluResult_out(a4), .rob_id_out(r4),
    .occupancy(o4)
`ifdef PIPE_STAGE_KILL_EN
    , .kill_valid(kill_valid), .kill_rob_id(kill_rob)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; valid = 0; stall = 0; itype = 0; pc = 0; alu = 0; rob = 0;
    kill_valid = 0; kill_rob = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %0b exp 0", v2); end
    checks++; if (s2 !== 1'b0) begin errors++; $display("FAIL reset_stall_out: got %0b exp 0", s2); end
    checks++; if (o2 !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d exp 0", o2); end
    checks++; if (p2 !== '0) begin errors++; $display("FAIL reset_pc_out: got %h exp 0", p2); end
    checks++; if (v4 !== 1'b0 || o4 !== 3'd0) begin errors++; $display("FAIL reset_d4: got v=%0b occ=%0d exp v=0 occ=0", v4, o4); end
  endtask

  task automatic test_streaming();
    logic [`WORD_SIZE-1:0] exp_pc [3];
    exp_pc[0] = 'h100; exp_pc[1] = 'h104; exp_pc[2] = 'h108;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      valid = 1; pc = exp_pc[i]; alu = exp_pc[i] + 1; rob = 6'(i + 1);
      tick();
      checks++; if (p2 !== exp_pc[i] || v2 !== 1'b1) begin errors++; $display("FAIL stream_pc%0d: got %h v=%0b exp %h v=1", i, p2, v2, exp_pc[i]); end
      checks++; if (o2 !== 2'd1) begin errors++; $display("FAIL stream_occ%0d: got %0d exp 1", i, o2); end
      checks++; if (a2 !== exp_pc[i] + 1) begin errors++; $display("FAIL stream_alu%0d: got %h exp %h", i, a2, exp_pc[i] + 1); end
    end
    valid = 0;
    tick();
    checks++; if (v2 !== 1'b0 || o2 !== 2'd0) begin errors++; $display("FAIL stream_drain: got v=%0b occ=%0d exp v=0 occ=0", v2, o2); end
    checks++; if (p2 !== 'h108) begin errors++; $display("FAIL stream_hold: got %h exp 108", p2); end
  endtask

  task automatic test_backpressure();
    do_reset();
    stall = 1; valid = 1; pc = 'h200;
    tick();
    checks++; if (o2 !== 2'd1 || s2 !== 1'b0 || p2 !== 'h200) begin errors++; $display("FAIL bp_first: got occ=%0d so=%0b pc=%h exp 1 0 200", o2, s2, p2); end
    pc = 'h204;
    tick();
    checks++; if (o2 !== 2'd2 || s2 !== 1'b1) begin errors++; $display("FAIL bp_full: got occ=%0d so=%0b exp 2 1", o2, s2); end
    pc = 'h208;
    tick();
    checks++; if (o2 !== 2'd2 || s2 !== 1'b1 || p2 !== 'h200 || v2 !== 1'b1) begin errors++; $display("FAIL bp_hold: got occ=%0d so=%0b pc=%h v=%0b exp 2 1 200 1", o2, s2, p2, v2); end
    stall = 0;
    tick();
    checks++; if (p2 !== 'h204 || o2 !== 2'd1 || s2 !== 1'b0) begin errors++; $display("FAIL bp_out1: got pc=%h occ=%0d so=%0b exp 204 1 0", p2, o2, s2); end
    tick();
    checks++; if (p2 !== 'h208 || v2 !== 1'b1 || o2 !== 2'd1) begin errors++; $display("FAIL bp_out2: got pc=%h v=%0b occ=%0d exp 208 1 1", p2, v2, o2); end
    valid = 0;
    tick();
    checks++; if (o2 !== 2'd0 || v2 !== 1'b0) begin errors++; $display("FAIL bp_empty: got occ=%0d v=%0b exp 0 0", o2, v2); end
  endtask

  task automatic test_wrap();
    logic [`WORD_SIZE-1:0] q[$];
    int mcount = 0;
    int k = 0;
    bit mpush, mpop;
    do_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      valid = (k < 12);
      pc    = 'h300 + 4 * k;
      stall = (cyc < 6) ? 1'b1 : ((cyc < 28) ? 1'($urandom_range(0, 1)) : 1'b0);
      mpush = valid && (mcount < 4);
      mpop  = (mcount != 0) && !stall;
      tick();
      if (mpop) void'(q.pop_front());
      if (mpush) begin q.push_back(pc); k++; end
      mcount = mcount + (mpush ? 1 : 0) - (mpop ? 1 : 0);
      checks++; if (o4 !== 3'(mcount) || o4 > 3'd4) begin errors++; $display("FAIL wrap_occ c%0d: got %0d exp %0d", cyc, o4, mcount); end
      checks++; if (v4 !== (mcount != 0)) begin errors++; $display("FAIL wrap_valid c%0d: got %0b exp %0b", cyc, v4, mcount != 0); end
      checks++; if (s4 !== (mcount == 4)) begin errors++; $display("FAIL wrap_stall_out c%0d: got %0b exp %0b", cyc, s4, mcount == 4); end
      if (mcount != 0) begin
        checks++; if (p4 !== q[0]) begin errors++; $display("FAIL wrap_pc c%0d: got %h exp %h", cyc, p4, q[0]); end
      end
    end
    checks++; if (k != 12 || o4 !== 3'd0) begin errors++; $display("FAIL wrap_all_out: got pushed=%0d occ=%0d exp 12 0", k, o4); end
  endtask

  task automatic test_flush();
    do_reset();
    stall = 1; valid = 1; pc = 'h400;
    tick();
    pc = 'h404;
    tick();
    checks++; if (s2 !== 1'b1) begin errors++; $display("FAIL flush_pre_full: got %0b exp 1", s2); end
    flush = 1; pc = 'h408;
    tick();
    flush = 0; valid = 0; stall = 0;
    checks++; if (v2 !== 1'b0 || o2 !== 2'd0 || s2 !== 1'b0) begin errors++; $display("FAIL flush_state: got v=%0b occ=%0d so=%0b exp 0 0 0", v2, o2, s2); end
    checks++; if (p2 !== 'h400) begin errors++; $display("FAIL flush_hold: got %h exp 400", p2); end
    tick();
    checks++; if (v2 !== 1'b0 || o2 !== 2'd0) begin errors++; $display("FAIL flush_no_push: got v=%0b occ=%0d exp 0 0", v2, o2); end
    valid = 1; pc = 'h40c;
    tick();
    valid = 0;
    checks++; if (p2 !== 'h40c || o2 !== 2'd1 || v2 !== 1'b1) begin errors++; $display("FAIL flush_restart: got pc=%h occ=%0d v=%0b exp 40c 1 1", p2, o2, v2); end
  endtask

`ifdef PIPE_STAGE_KILL_EN
  task automatic test_kill();
    do_reset();
    stall = 1; valid = 1;
    pc = 'h500; rob = 3; tick();
    pc = 'h504; rob = 5; tick();
    pc = 'h508; rob = 3; tick();
    valid = 0; kill_valid = 1; kill_rob = 3;
    tick();
    kill_valid = 0;
    checks++; if (o4 !== 3'd3 || v4 !== 1'b0) begin errors++; $display("FAIL kill_mark: got occ=%0d v=%0b exp 3 0", o4, v4); end
    tick();
    checks++; if (o4 !== 3'd2 || v4 !== 1'b1 || r4 !== 6'd5 || p4 !== 'h504) begin errors++; $display("FAIL kill_bubble_drop: got occ=%0d v=%0b rob=%0d pc=%h exp 2 1 5 504", o4, v4, r4, p4); end
    tick();
    checks++; if (o4 !== 3'd2 || v4 !== 1'b1) begin errors++; $display("FAIL kill_live_held: got occ=%0d v=%0b exp 2 1", o4, v4); end
    stall = 0;
    tick();
    checks++; if (o4 !== 3'd1 || v4 !== 1'b0) begin errors++; $display("FAIL kill_tail_bubble: got occ=%0d v=%0b exp 1 0", o4, v4); end
    tick();
    checks++; if (o4 !== 3'd0 || v4 !== 1'b0) begin errors++; $display("FAIL kill_drained: got occ=%0d v=%0b exp 0 0", o4, v4); end
    valid = 1; rob = 7; kill_valid = 1; kill_rob = 7;
    tick();
    valid = 0; kill_valid = 0;
    checks++; if (o4 !== 3'd1 || v4 !== 1'b0) begin errors++; $display("FAIL kill_same_cycle_push: got occ=%0d v=%0b exp 1 0", o4, v4); end
    tick();
    checks++; if (o4 !== 3'd0) begin errors++; $display("FAIL kill_push_drop: got occ=%0d exp 0", o4); end
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_flush();
`ifdef PIPE_STAGE_KILL_EN
    test_kill();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
